weighted_roundrobin: RTL and testbench
======================================

# weighted_roundrobin

Weighted round-robin arbiter that picks, each clock, one of four virtual channels and forwards that channel's 4-bit pop data to a single registered output. The weights are a 64-slot schedule table, each slot naming a channel; a channel's share equals its slot count. It sits between the four virtual-channel FIFOs and the shared downstream link. The table has a built-in default and can be overwritten at run time through a 128-bit load bus.

## Interface
- No parameters. Table depth is fixed at 64 slots × 2 bits; data width is fixed at 4 bits.
- clk0  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- enb  input  1  enable; when low, pointer and output hold.
- init  input  1  table load strobe, synchronous, one-cycle pulse.
- tester_input  input  128  new schedule table; slot k = bits [2k+1:2k], value = channel ID 0..3.
- pop_vchannel0..pop_vchannel3  input  4 each  head data of virtual channels 0..3.
- empty_vchannel0..empty_vchannel3  input  1 each  high = channel has no data.
- wghtd_output  output  4  registered data of the granted channel; 4'h0 when nothing is granted.

## Operation
- State: 64×2-bit schedule table; 6-bit slot pointer `ptr`; 4-bit output register.
- Reset state: slot k = k mod 4, so the default order is 0,1,2,3 repeated. `ptr` = 0. wghtd_output = 4'h0.
- Priority per edge is rst > init > enb.
- Load (init=1, rst=0):
  - table <= tester_input; `ptr` <= 0; wghtd_output <= 4'h0.
  - Load happens regardless of enb.
  - No grant is issued on the load edge.
- Arbitration (enb=1, init=0, rst=0):
  - Let c = table[ptr].
  - If empty_vchannel[c]=0, grant c.
  - Otherwise fall back: grant the first non-empty channel in circular order c+1, c+2, c+3 (mod 4).
  - If all four channels are empty, no grant.
  - wghtd_output <= pop_vchannel[granted], or 4'h0 if no grant.
  - `ptr` <= ptr+1, wrapping 63→0, every enabled cycle whether or not a grant was issued.
- Hold (enb=0, no rst/init): `ptr`, table and wghtd_output all unchanged.
- Grant decisions are combinational on the current inputs. No data is stored inside the block; the FIFOs own the data.

## Timing
- One-cycle latency. Inputs sampled at edge N appear on wghtd_output after edge N and stay stable until edge N+1.
- With rst deasserted and enb high, the first enabled edge evaluates slot 0.
- On the edge after init, slot 0 of the new table is evaluated.
- The table may be reloaded at any time. The previous schedule is abandoned and `ptr` restarts at 0.
- rst mid-schedule: on the next edge, the table returns to the default, `ptr` = 0 and the output = 0. This holds even if init or enb is also high.
- Empty flags may toggle every cycle. Only the values present at the sampling edge matter.
- Pointer wrap: after slot 63 the next enabled edge evaluates slot 0. There is no bubble at the wrap.

## Test plan
- Reset: hold rst=1 for 2 edges with arbitrary inputs → wghtd_output = 4'h0. Then set rst=0, enb=1, all channels non-empty, pop = a,b,c,d → outputs a,b,c,d,a,b… from the default table.
- Load: pulse init for one cycle with tester_input slots 0..3 = 2,0,1,2; all channels non-empty → 4'h0 on the load edge, then c,a,b,c. After 64 enabled cycles the sequence repeats from slot 0.
- Fallback: table slot = channel 2, empty_vchannel2=1, channel 3 non-empty → output d. With channels 2 and 3 empty and channel 0 non-empty → output a.
- All channels empty for 3 cycles → output 4'h0 each cycle. `ptr` still advances 3, verified by the slot granted once channels refill.
- Hold: drop enb for 5 cycles mid-sequence → output frozen. On resume, arbitration continues from the next unserved slot.
- Reset mid-operation: assert rst together with init after 20 enabled cycles of a loaded table → output 0, default table restored (a,b,c,d order resumes), and the loaded table is discarded.

Source files
------------

// File: rtl/weighted_roundrobin.sv
// Weighted round-robin arbiter: 64-slot schedule table picks one of four
// virtual channels per cycle, with circular fallback past empty channels.
module weighted_roundrobin (
  input  logic         clk0,
  input  logic         rst,
  input  logic         enb,
  input  logic         init,
  input  logic [127:0] tester_input,
  input  logic [3:0]   pop_vchannel0,
  input  logic [3:0]   pop_vchannel1,
  input  logic [3:0]   pop_vchannel2,
  input  logic [3:0]   pop_vchannel3,
  input  logic         empty_vchannel0,
  input  logic         empty_vchannel1,
  input  logic         empty_vchannel2,
  input  logic         empty_vchannel3,
  output logic [3:0]   wghtd_output
);

  // Default order 0,1,2,3 repeated: each byte packs slots 3..0 as 3,2,1,0.
  localparam logic [127:0] DefTbl = {16{8'hE4}};

  logic [127:0] tbl_q, tbl_d;
  logic [5:0]   ptr_q, ptr_d;
  logic [3:0]   out_q, out_d;

  logic [3:0] empty;
  logic [3:0] pop [4];
  logic [1:0] slot_ch;
  logic [1:0] gnt_ch;
  logic [1:0] cand;
  logic       gnt_vld;

  assign empty  = {empty_vchannel3, empty_vchannel2,
                   empty_vchannel1, empty_vchannel0};
  assign pop[0] = pop_vchannel0;
  assign pop[1] = pop_vchannel1;
  assign pop[2] = pop_vchannel2;
  assign pop[3] = pop_vchannel3;

  assign slot_ch = tbl_q[{ptr_q, 1'b0} +: 2];

  // Grant: scheduled channel first, then c+1, c+2, c+3 circularly.
  // Scan from the farthest offset so the nearest non-empty one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = slot_ch;
    cand    = slot_ch;
    for (int i = 3; i >= 0; i--) begin
      cand = slot_ch + 2'(i);
      if (!empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  // Next state: reset beats load beats enable; otherwise hold.
  always_comb begin
    tbl_d = tbl_q;
    ptr_d = ptr_q;
    out_d = out_q;
    if (init) begin
      tbl_d = tester_input;
      ptr_d = '0;
      out_d = '0;
    end else if (enb) begin
      ptr_d = ptr_q + 6'd1;
      out_d = gnt_vld ? pop[gnt_ch] : 4'h0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      tbl_q <= DefTbl;
      ptr_q <= '0;
      out_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      ptr_q <= ptr_d;
      out_q <= out_d;
    end
  end

  assign wghtd_output = out_q;

endmodule

// File: tb/tb_weighted_roundrobin.sv
// Bench for weighted_roundrobin: directed vector table, hand sequences
// for wrap/hold/all-empty, and randomized traffic against a reference model.
module tb_weighted_roundrobin;

  logic         clk0 = 1'b0;
  logic         rst, enb, init;
  logic [127:0] tester_input;
  logic [3:0]   pop [4];
  logic [3:0]   emp;
  logic [3:0]   wghtd_output;

  int errors = 0;
  int checks = 0;

  always #5 clk0 = ~clk0;

  weighted_roundrobin dut (
    .clk0            (clk0),
    .rst             (rst),
    .enb             (enb),
    .init            (init),
    .tester_input    (tester_input),
    .pop_vchannel0   (pop[0]),
    .pop_vchannel1   (pop[1]),
    .pop_vchannel2   (pop[2]),
    .pop_vchannel3   (pop[3]),
    .empty_vchannel0 (emp[0]),
    .empty_vchannel1 (emp[1]),
    .empty_vchannel2 (emp[2]),
    .empty_vchannel3 (emp[3]),
    .wghtd_output    (wghtd_output)
  );

  // Reference model: schedule as an int array, pointer as int.
  int         m_sched [64];
  int         m_ptr;
  logic [3:0] m_out;

  task automatic model_step();
    int c, g;
    if (rst) begin
      for (int k = 0; k < 64; k++) m_sched[k] = k % 4;
      m_ptr = 0;
      m_out = 4'h0;
    end else if (init) begin
      for (int k = 0; k < 64; k++)
        m_sched[k] = int'(tester_input[2*k +: 2]);
      m_ptr = 0;
      m_out = 4'h0;
    end else if (enb) begin
      c = m_sched[m_ptr];
      g = -1;
      for (int off = 0; off < 4 && g < 0; off++)
        if (!emp[(c + off) % 4]) g = (c + off) % 4;
      m_out = (g < 0) ? 4'h0 : pop[g];
      m_ptr = (m_ptr + 1) % 64;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if (wghtd_output !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, wghtd_output, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       init;
    logic       enb;
    logic [3:0] emp;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [17];

  logic [127:0] ld_tbl;
  logic [3:0]   hold_val;
  int           n;

  initial begin
    // Pop data a,b,c,d = A,B,C,D; load table slots 2,0,1,2 repeating.
    vecs[0]  = '{0, 0, 1, 4'b0000, 4'hA};
    vecs[1]  = '{0, 0, 1, 4'b0000, 4'hB};
    vecs[2]  = '{0, 0, 1, 4'b0100, 4'hD};
    vecs[3]  = '{0, 0, 1, 4'b1000, 4'hA};
    vecs[4]  = '{0, 0, 1, 4'b1111, 4'h0};
    vecs[5]  = '{0, 0, 0, 4'b0000, 4'h0};
    vecs[6]  = '{0, 0, 1, 4'b0000, 4'hB};
    vecs[7]  = '{1, 0, 1, 4'b0000, 4'h0};
    vecs[8]  = '{0, 0, 1, 4'b0000, 4'hA};
    vecs[9]  = '{0, 1, 0, 4'b0000, 4'h0};
    vecs[10] = '{0, 0, 1, 4'b0000, 4'hC};
    vecs[11] = '{0, 0, 1, 4'b0000, 4'hA};
    vecs[12] = '{0, 0, 1, 4'b0011, 4'hC};
    vecs[13] = '{0, 0, 1, 4'b0100, 4'hD};
    vecs[14] = '{1, 1, 1, 4'b0000, 4'h0};
    vecs[15] = '{0, 0, 1, 4'b0000, 4'hA};
    vecs[16] = '{0, 0, 1, 4'b0000, 4'hB};

    rst = 1; init = 0; enb = 1; emp = 4'b0101;
    tester_input = {4{32'hDEADBEEF}};
    pop[0] = 4'h3; pop[1] = 4'h7; pop[2] = 4'h9; pop[3] = 4'h5;
    tick(); check("reset_edge1", 4'h0);
    init = 1;
    tick(); check("reset_edge2", 4'h0);

    pop[0] = 4'hA; pop[1] = 4'hB; pop[2] = 4'hC; pop[3] = 4'hD;
    tester_input = {16{8'h92}};
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; init = vecs[i].init;
      enb = vecs[i].enb; emp = vecs[i].emp;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Random table: wrap past slot 63, all-empty gap, enable hold.
    ld_tbl = {$urandom, $urandom, $urandom, $urandom};
    tester_input = ld_tbl;
    rst = 0; init = 1; enb = 1; emp = 4'b0000;
    tick(); check("load_edge", 4'h0);
    init = 0;
    n = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      check($sformatf("wrap_n%0d", n), pop[ld_tbl[2*(n%64) +: 2]]);
      n++;
    end
    emp = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(); check("all_empty", 4'h0);
      n++;
    end
    emp = 4'b0000;
    tick(); check("refill_slot", pop[ld_tbl[2*(n%64) +: 2]]);
    n++;
    hold_val = pop[ld_tbl[2*((n-1)%64) +: 2]];
    enb = 0;
    for (int i = 0; i < 5; i++) begin
      pop[i%4] = pop[i%4] ^ 4'h0;
      tick(); check("hold", hold_val);
    end
    enb = 1;
    tick(); check("resume_slot", pop[ld_tbl[2*(n%64) +: 2]]);
    n++;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      init = ($urandom_range(0, 49) == 0);
      enb  = ($urandom_range(0, 9) != 0);
      emp  = 4'($urandom);
      for (int k = 0; k < 4; k++) pop[k] = 4'($urandom);
      if (init) tester_input = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check($sformatf("rand%0d", i), m_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
